// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage initiator for the word-addressed data memory.
// One request at a time; byte address -> word index, registered write strobe
// with a setup cycle ahead of the pulse, extended load data on completion.
// Build option MAU_BYTE_LANES_EN: when defined, byte/half loads and stores
// (read-modify-write) are supported; otherwise only word accesses are legal.
//
// state    | meaning
// IDLE     | ready for a request
// READ     | memory read; load data or old word captured at end of cycle
// WR_SETUP | address/data stable, strobe low
// WR_PULSE | strobe high, memory writes on its rising edge
// DONE     | one-cycle response (resp_valid)
module mem_access_unit #(
  parameter int DATA_MEM_LO = 0,
  parameter int DATA_MEM_HI = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        sig_mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_READ     = 3'd1;
  localparam logic [2:0] S_WR_SETUP = 3'd2;
  localparam logic [2:0] S_WR_PULSE = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  // 33-bit bounds so the low-bound test stays meaningful when DATA_MEM_LO is 0
  localparam logic [32:0] LO33 = 33'(DATA_MEM_LO);
  localparam logic [32:0] HI33 = 33'(DATA_MEM_HI);

  logic [2:0]  r_state;
  logic        r_error;
  logic [31:0] r_rdata;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_mem_write;

  logic [31:0] w_word_idx;
  logic        w_range_err;
  logic        w_size_err;
  logic        w_err;
  logic        w_accept;

`ifdef MAU_BYTE_LANES_EN
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;
  logic [4:0]  w_shamt;
  logic [31:0] w_shifted;
  logic [31:0] w_lane_mask;
  logic [31:0] w_load;
  logic [31:0] w_merge;
`else
  logic        w_unused_in;
  assign w_unused_in = req_unsigned;
`endif

  assign w_word_idx  = {2'b00, req_addr[31:2]};
  assign w_range_err = !((({1'b0, w_word_idx} + 33'd1) > LO33) &&
                         ({1'b0, w_word_idx} <= HI33));
`ifdef MAU_BYTE_LANES_EN
  assign w_size_err  = (req_size == 2'b11) ||
                       ((req_size == 2'b01) && req_addr[0]) ||
                       ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign w_size_err  = (req_size != 2'b10) || (req_addr[1:0] != 2'b00);
`endif
  assign w_err       = w_size_err || w_range_err;
  assign w_accept    = req_valid && (r_state == S_IDLE);

  assign req_ready      = (r_state == S_IDLE);
  assign resp_valid     = (r_state == S_DONE);
  assign resp_rdata     = r_rdata;
  assign resp_error     = r_error;
  assign sig_mem_write  = r_mem_write;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_wdata;

`ifdef MAU_BYTE_LANES_EN
  // lane extraction for loads and lane merge for sub-word stores
  always_comb begin
    w_shamt     = {r_lane, 3'b000};
    w_shifted   = mem_read_data >> w_shamt;
    w_lane_mask = (r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
    case (r_size)
      2'b00:   w_load = r_unsigned ? {24'd0, w_shifted[7:0]}
                                   : {{24{w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_load = r_unsigned ? {16'd0, w_shifted[15:0]}
                                   : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: w_load = mem_read_data;
    endcase
    w_merge = (mem_read_data & ~(w_lane_mask << w_shamt)) |
              ((r_wdata & w_lane_mask) << w_shamt);
  end
`endif

  // access sequencer; all outputs are registered or decoded from state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_error     <= 1'b0;
      r_rdata     <= 32'd0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_write <= 1'b0;
`ifdef MAU_BYTE_LANES_EN
      r_write     <= 1'b0;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_lane      <= 2'b00;
      r_wdata     <= 32'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_error <= w_err;
            r_rdata <= 32'd0;
`ifdef MAU_BYTE_LANES_EN
            r_write    <= req_write;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_lane     <= req_addr[1:0];
            r_wdata    <= req_wdata;
`endif
            if (w_err) begin
              r_state <= S_DONE;
            end else begin
              r_mem_addr <= w_word_idx;
              if (!req_write) begin
                r_state <= S_READ;
`ifdef MAU_BYTE_LANES_EN
              end else if (req_size != 2'b10) begin
                r_state <= S_READ;
`endif
              end else begin
                r_mem_wdata <= req_wdata;
                r_state     <= S_WR_SETUP;
              end
            end
          end
        end
        S_READ: begin
`ifdef MAU_BYTE_LANES_EN
          if (r_write) begin
            r_mem_wdata <= w_merge;
            r_state     <= S_WR_SETUP;
          end else begin
            r_rdata <= w_load;
            r_state <= S_DONE;
          end
`else
          r_rdata <= mem_read_data;
          r_state <= S_DONE;
`endif
        end
        S_WR_SETUP: begin
          r_mem_write <= 1'b1;
          r_state     <= S_WR_PULSE;
        end
        S_WR_PULSE: begin
          r_mem_write <= 1'b0;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          r_error <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory interface; sits in the MEM stage of the pipelined CPU between pipeline control and the word-addressed data memory.
- Accepts one load/store request at a time and translates byte addresses to word indices.
- Sub-word stores are done as read-modify-write. The unit generates the clean, setup-qualified rising edge on sig_mem_write that the memory samples, and returns load data with sign/zero extension.

Parameters:
- DATA_MEM_LO, 0, lowest valid word index of data memory.
- DATA_MEM_HI, 1023, highest valid word index of data memory.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  loads: 1 zero-extend, 0 sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle pulse: request complete.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_error  out  1  qualified by resp_valid: misaligned, out-of-range or reserved size.
- sig_mem_write  out  1  memory write strobe; memory writes on its rising edge.
- mem_addr  out  32  word index = {2'b00, req_addr[31:2]}.
- mem_write_data  out  32  word to write.
- mem_read_data  in  32  combinational read of mem[mem_addr].

Behaviour:
- Reset (async, rst_n low): state IDLE. req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, sig_mem_write=0, mem_addr=0, mem_write_data=0.
- Handshake: the request is accepted on the clk edge where req_valid && req_ready. All request fields are registered at acceptance, and inputs are ignored until the unit returns to IDLE.
- Error check at acceptance:
  - size 11 is an error.
  - Half with addr[0]=1 is an error.
  - Word with addr[1:0]!=0 is an error.
  - A word index outside DATA_MEM_LO..DATA_MEM_HI is an error.
  - On error, go to DONE with resp_error=1. Memory is never touched and sig_mem_write stays 0.
- States: IDLE, READ, WR_SETUP, WR_PULSE, DONE.
  - Load: IDLE -> READ (drive mem_addr; capture mem_read_data at end of cycle) -> DONE.
  - Word store: IDLE -> WR_SETUP (mem_addr and mem_write_data stable, strobe 0) -> WR_PULSE (strobe 1) -> DONE (strobe 0).
  - Sub-word store: IDLE -> READ (capture old word) -> WR_SETUP (merged word driven) -> WR_PULSE -> DONE.
- Latency from acceptance edge to resp_valid: load 2 cycles, word store 3, sub-word store 4, error 1.
- DONE lasts exactly one cycle: resp_valid=1, then go to IDLE. req_ready=0 during DONE, so back-to-back requests have one idle bubble.
- Byte lanes are little-endian: lane n = bits [8n+7:8n].
  - Byte uses lane addr[1:0].
  - Half uses lanes addr[1]*2 and addr[1]*2+1.
  - Merge replaces only the addressed lanes with req_wdata[7:0] or req_wdata[15:0]. Other lanes are kept from the captured word.
- Load extract: shift the addressed lanes to bit 0, then extend per req_unsigned. Word loads pass unchanged.
- mem_addr and mem_write_data hold their last values outside active states.
- sig_mem_write is high only in WR_PULSE; it is a registered output, so it is glitch-free.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. A WR_PULSE cut short leaves the memory word undefined, which is acceptable.

Optional Feature:
- Macro: MAU_BYTE_LANES_EN.
- Defined: byte and halfword accesses are supported as described, including read-modify-write.
- Undefined: only word accesses are supported. req_size 00/01 is treated as an error (resp_error=1, latency 1, no memory access). The READ-for-merge path and the extraction/merge logic are not built; word stores go IDLE -> WR_SETUP.

Test Plan:
- Word store addr 0x10, data 0xDEADBEEF:
  - mem_addr=4.
  - sig_mem_write high exactly one cycle, in the 2nd cycle after accept.
  - resp_valid 3 cycles after accept; mem[4]=0xDEADBEEF.
- With mem[4]=0xDEADBEEF:
  - Byte store addr 0x11, data 0x55 -> mem[4]=0xDEAD55EF; resp_valid after 4 cycles.
- With mem[4]=0xDEAD55EF:
  - Signed byte load 0x13 -> resp_rdata=0xFFFFFFDE.
  - Unsigned byte load 0x13 -> 0x000000DE.
  - Signed half load 0x12 -> 0xFFFFDEAD.
- Errors:
  - Word load addr 0x12 -> resp_error=1 and resp_rdata=0, 1 cycle after accept; sig_mem_write never rises.
  - Word index 1024 with DATA_MEM_HI=1023 -> same response.
- Back-to-back: req_valid held high with two loads -> second accepted only after the DONE cycle; req_ready=0 throughout the first access.
- rst_n asserted during WR_SETUP -> all outputs reset immediately, no sig_mem_write edge; the next request is accepted normally.
